// File: rtl/vga_timing_pkg.sv
// 640x480@60 timing constants and small decode helpers, shared by the sync
// generator and the renderer.
package vga_timing_pkg;

   localparam int unsigned CNT_W         = 10;

   localparam int unsigned VGA_H_DISPLAY = 640;
   localparam int unsigned VGA_H_FP      = 16;
   localparam int unsigned VGA_H_SYNC    = 96;
   localparam int unsigned VGA_H_BP      = 48;
   localparam int unsigned VGA_H_TOTAL   = VGA_H_DISPLAY + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

   localparam int unsigned VGA_V_DISPLAY = 480;
   localparam int unsigned VGA_V_FP      = 10;
   localparam int unsigned VGA_V_SYNC    = 2;
   localparam int unsigned VGA_V_BP      = 33;
   localparam int unsigned VGA_V_TOTAL   = VGA_V_DISPLAY + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

   localparam int unsigned VGA_DIV       = 4;

   // True when v lies in [lo, lo+len-1]; compared as unsigned 32-bit values.
   function automatic logic in_span(input logic [CNT_W-1:0] v,
                                    input int unsigned      lo,
                                    input int unsigned      len);
      int unsigned vi;
      vi = {{(32-CNT_W){1'b0}}, v};
      return (vi >= lo) && (vi < lo + len);
   endfunction

endpackage

// File: rtl/pix_tick_div.sv
// Pixel-rate enable: free-running 0..DIV-1 counter, p_tick high on the last count.
module pix_tick_div #(
   parameter int unsigned DIV = 4
)(
   input  logic clk_nexys,
   input  logic reset,
   output logic p_tick
);

   localparam int unsigned     DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(DIV - 1);

   logic [DIV_W-1:0] div_q;

   always_ff @(posedge clk_nexys) begin
      if (reset)
         div_q <= '0;
      else if (div_q == DIV_MAX)
         div_q <= '0;
      else
         div_q <= div_q + DIV_W'(1);
   end

   assign p_tick = (div_q == DIV_MAX);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster counters and sync/blanking decode; decoded outputs are registered
// from the next-state counters so they line up with PIX_X/PIX_Y.
module vga_sync_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_DISPLAY = VGA_H_DISPLAY,
   parameter int unsigned H_FP      = VGA_H_FP,
   parameter int unsigned H_SYNC    = VGA_H_SYNC,
   parameter int unsigned H_BP      = VGA_H_BP,
   parameter int unsigned V_DISPLAY = VGA_V_DISPLAY,
   parameter int unsigned V_FP      = VGA_V_FP,
   parameter int unsigned V_SYNC    = VGA_V_SYNC,
   parameter int unsigned V_BP      = VGA_V_BP,
   parameter int unsigned DIV       = VGA_DIV
)(
   input  logic             CLK_NEXYS,
   input  logic             RESET,
   output logic             P_TICK,
   output logic [CNT_W-1:0] PIX_X,
   output logic [CNT_W-1:0] PIX_Y,
   output logic             HSYNC,
   output logic             VSYNC,
   output logic             VIDEO_ON,
   output logic             FRAME_START
);

   localparam int unsigned      H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
   localparam int unsigned      V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;
   localparam logic [CNT_W-1:0] H_MAX   = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_MAX   = CNT_W'(V_TOTAL - 1);

   logic [CNT_W-1:0] x_q, y_q;
   logic [CNT_W-1:0] x_nxt, y_nxt;
   logic             h_end, v_end;

   pix_tick_div #(.DIV(DIV)) u_tick (
      .clk_nexys (CLK_NEXYS),
      .reset     (RESET),
      .p_tick    (P_TICK)
   );

   assign h_end = (x_q == H_MAX);
   assign v_end = (y_q == V_MAX);

   always_comb begin
      x_nxt = x_q;
      y_nxt = y_q;
      if (P_TICK) begin
         if (h_end) begin
            x_nxt = '0;
            y_nxt = v_end ? '0 : y_q + CNT_W'(1);
         end else begin
            x_nxt = x_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge CLK_NEXYS) begin
      if (RESET) begin
         x_q         <= '0;
         y_q         <= '0;
         HSYNC       <= 1'b1;
         VSYNC       <= 1'b1;
         VIDEO_ON    <= 1'b0;
         FRAME_START <= 1'b0;
      end else begin
         x_q         <= x_nxt;
         y_q         <= y_nxt;
         HSYNC       <= ~in_span(x_nxt, H_DISPLAY + H_FP, H_SYNC);
         VSYNC       <= ~in_span(y_nxt, V_DISPLAY + V_FP, V_SYNC);
         VIDEO_ON    <= in_span(x_nxt, 0, H_DISPLAY) && in_span(y_nxt, 0, V_DISPLAY);
         // Only the tick that wraps the last pixel of the last line starts a frame.
         FRAME_START <= P_TICK && h_end && v_end;
      end
   end

   assign PIX_X = x_q;
   assign PIX_Y = y_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default-timing instance for line-level behaviour and a
// shrunken-timing instance so frame wrap and vertical decode fit in a short run.
module tb_vga_sync_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_d, rst_s;
   logic       tick_d, hs_d, vs_d, von_d, fs_d;
   logic [9:0] x_d, y_d;
   logic       tick_s, hs_s, vs_s, von_s, fs_s;
   logic [9:0] x_s, y_s;

   vga_sync_gen dut_d (
      .CLK_NEXYS   (clk),
      .RESET       (rst_d),
      .P_TICK      (tick_d),
      .PIX_X       (x_d),
      .PIX_Y       (y_d),
      .HSYNC       (hs_d),
      .VSYNC       (vs_d),
      .VIDEO_ON    (von_d),
      .FRAME_START (fs_d)
   );

   // Small raster: H_TOTAL=32 (hsync x 20..27), V_TOTAL=19 (vsync y 14..15), 2432 cycles/frame.
   vga_sync_gen #(
      .H_DISPLAY(16), .H_FP(4), .H_SYNC(8), .H_BP(4),
      .V_DISPLAY(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
      .DIV(4)
   ) dut_s (
      .CLK_NEXYS   (clk),
      .RESET       (rst_s),
      .P_TICK      (tick_s),
      .PIX_X       (x_s),
      .PIX_Y       (y_s),
      .HSYNC       (hs_s),
      .VSYNC       (vs_s),
      .VIDEO_ON    (von_s),
      .FRAME_START (fs_s)
   );

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       hs;
      logic       vs;
      logic       von;
      logic       fs;
      logic       tick;
   } obs_t;

   typedef struct {
      bit          sel;
      int unsigned k;
      obs_t        exp;
   } vec_t;

   int          checks   = 0;
   int          failures = 0;
   int unsigned k_cur    = 0;
   obs_t        exp_q[$];
   vec_t        tab_a[14];
   vec_t        tab_b[15];

   function automatic vec_t mk(input bit sel, input int unsigned k,
                               input int x, input int y, input logic hs, input logic vs,
                               input logic von, input logic fs, input logic tick);
      vec_t v;
      v.sel = sel;
      v.k   = k;
      v.exp = '{x: 10'(x), y: 10'(y), hs: hs, vs: vs, von: von, fs: fs, tick: tick};
      return v;
   endfunction

   function automatic obs_t observe(input bit sel);
      obs_t o;
      if (sel) o = '{x: x_s, y: y_s, hs: hs_s, vs: vs_s, von: von_s, fs: fs_s, tick: tick_s};
      else     o = '{x: x_d, y: y_d, hs: hs_d, vs: vs_d, von: von_d, fs: fs_d, tick: tick_d};
      return o;
   endfunction

   task automatic compare(input string name, input obs_t act, input obs_t exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got x=%0d y=%0d hs=%b vs=%b von=%b fs=%b tick=%b, expected x=%0d y=%0d hs=%b vs=%b von=%b fs=%b tick=%b",
                  name, act.x, act.y, act.hs, act.vs, act.von, act.fs, act.tick,
                  exp.x, exp.y, exp.hs, exp.vs, exp.von, exp.fs, exp.tick);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic advance(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
      k_cur += n;
   endtask

   task automatic run_vec(input vec_t v);
      obs_t exp;
      if (v.k > k_cur) advance(v.k - k_cur);
      exp_q.push_back(v.exp);
      exp = exp_q.pop_front();
      compare($sformatf("%s_k%0d", v.sel ? "small" : "dflt", v.k), observe(v.sel), exp);
   endtask

   initial begin
      int ticks, bad_ticks, fs_cnt, fs_k, vlow, vviol, hlow, hviol;

      //               sel  k      x    y   hs vs von fs tick
      tab_a[0]  = mk(0,     0,    0,   0, 1, 1, 0, 0, 0);
      tab_a[1]  = mk(0,     1,    0,   0, 1, 1, 1, 0, 0);
      tab_a[2]  = mk(0,     3,    0,   0, 1, 1, 1, 0, 1);
      tab_a[3]  = mk(0,     4,    1,   0, 1, 1, 1, 0, 0);
      tab_a[4]  = mk(0,     7,    1,   0, 1, 1, 1, 0, 1);
      tab_a[5]  = mk(0,     8,    2,   0, 1, 1, 1, 0, 0);
      tab_a[6]  = mk(0,  2556,  639,   0, 1, 1, 1, 0, 0);
      tab_a[7]  = mk(0,  2560,  640,   0, 1, 1, 0, 0, 0);
      tab_a[8]  = mk(0,  2620,  655,   0, 1, 1, 0, 0, 0);
      tab_a[9]  = mk(0,  2624,  656,   0, 0, 1, 0, 0, 0);
      tab_a[10] = mk(0,  3004,  751,   0, 0, 1, 0, 0, 0);
      tab_a[11] = mk(0,  3008,  752,   0, 1, 1, 0, 0, 0);
      tab_a[12] = mk(0, 35199,  799,  10, 1, 1, 0, 0, 1);
      tab_a[13] = mk(0, 35200,    0,  11, 1, 1, 1, 0, 0);

      tab_b[0]  = mk(1,     0,    0,   0, 1, 1, 0, 0, 0);
      tab_b[1]  = mk(1,    64,   16,   0, 1, 1, 0, 0, 0);
      tab_b[2]  = mk(1,    76,   19,   0, 1, 1, 0, 0, 0);
      tab_b[3]  = mk(1,    80,   20,   0, 0, 1, 0, 0, 0);
      tab_b[4]  = mk(1,   108,   27,   0, 0, 1, 0, 0, 0);
      tab_b[5]  = mk(1,   112,   28,   0, 1, 1, 0, 0, 0);
      tab_b[6]  = mk(1,  1468,   15,  11, 1, 1, 1, 0, 0);
      tab_b[7]  = mk(1,  1536,    0,  12, 1, 1, 0, 0, 0);
      tab_b[8]  = mk(1,  1788,   31,  13, 1, 1, 0, 0, 0);
      tab_b[9]  = mk(1,  1792,    0,  14, 1, 0, 0, 0, 0);
      tab_b[10] = mk(1,  2044,   31,  15, 1, 0, 0, 0, 0);
      tab_b[11] = mk(1,  2048,    0,  16, 1, 1, 0, 0, 0);
      tab_b[12] = mk(1,  2431,   31,  18, 1, 1, 0, 0, 1);
      tab_b[13] = mk(1,  2432,    0,   0, 1, 1, 1, 1, 0);
      tab_b[14] = mk(1,  2433,    0,   0, 1, 1, 1, 0, 0);

      rst_d = 1'b1;
      rst_s = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      // Default-timing instance: k counts edges since its reset was released.
      k_cur = 0;
      run_vec(tab_a[0]);
      rst_d = 1'b0;
      for (int i = 1; i < 14; i++) run_vec(tab_a[i]);

      // Reset coincident with a pixel tick mid-line.
      advance(36403 - k_cur);
      compare("dflt_pre_reset", observe(0), '{x: 10'd300, y: 10'd11, hs: 1'b1, vs: 1'b1, von: 1'b1, fs: 1'b0, tick: 1'b1});
      rst_d = 1'b1;
      advance(1);
      compare("dflt_reset_on_tick", observe(0), '{x: 10'd0, y: 10'd0, hs: 1'b1, vs: 1'b1, von: 1'b0, fs: 1'b0, tick: 1'b0});
      rst_d = 1'b0;
      k_cur = 0;
      advance(1);
      compare("dflt_rerelease_k1", observe(0), '{x: 10'd0, y: 10'd0, hs: 1'b1, vs: 1'b1, von: 1'b1, fs: 1'b0, tick: 1'b0});
      ticks = 0;
      bad_ticks = 0;
      for (int k = 2; k <= 40; k++) begin
         advance(1);
         if (tick_d) begin
            ticks++;
            if ((k_cur % 4) != 3) bad_ticks++;
         end
      end
      check_int("dflt_tick_count_40", ticks, 10);
      check_int("dflt_tick_phase", bad_ticks, 0);
      check_int("dflt_x_at_k40", int'(x_d), 10);

      // Small-timing instance.
      k_cur = 0;
      run_vec(tab_b[0]);
      rst_s = 1'b0;
      for (int i = 1; i < 15; i++) run_vec(tab_b[i]);

      // One full frame after the first FRAME_START: period and sync windows.
      fs_cnt = 0;
      fs_k   = 0;
      vlow   = 0;
      vviol  = 0;
      hlow   = 0;
      hviol  = 0;
      for (int k = 2434; k <= 4870; k++) begin
         advance(1);
         if (fs_s) begin
            fs_cnt++;
            fs_k = int'(k_cur);
         end
         if (!vs_s) begin
            vlow++;
            if (y_s != 10'd14 && y_s != 10'd15) vviol++;
         end
         if (!hs_s) begin
            hlow++;
            if (x_s < 10'd20 || x_s > 10'd27) hviol++;
         end
      end
      check_int("small_frame_start_count", fs_cnt, 1);
      check_int("small_frame_period", fs_k - 2432, 2432);
      check_int("small_vsync_low_cycles", vlow, 256);
      check_int("small_vsync_outside_lines", vviol, 0);
      check_int("small_hsync_low_cycles", hlow, 608);
      check_int("small_hsync_outside_cols", hviol, 0);

      // Reset landing exactly on the wrap tick must not produce FRAME_START.
      advance(7295 - k_cur);
      compare("small_pre_wrap_reset", observe(1), '{x: 10'd31, y: 10'd18, hs: 1'b1, vs: 1'b1, von: 1'b0, fs: 1'b0, tick: 1'b1});
      rst_s = 1'b1;
      advance(1);
      compare("small_reset_at_wrap", observe(1), '{x: 10'd0, y: 10'd0, hs: 1'b1, vs: 1'b1, von: 1'b0, fs: 1'b0, tick: 1'b0});
      advance(1);
      compare("small_reset_held", observe(1), '{x: 10'd0, y: 10'd0, hs: 1'b1, vs: 1'b1, von: 1'b0, fs: 1'b0, tick: 1'b0});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 SHALL have parameter H_DISPLAY, default 640, meaning visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 16, meaning horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, meaning horizontal sync width in pixels.
REQ-004 SHALL have parameter H_BP, default 48, meaning horizontal back porch in pixels.
REQ-005 SHALL have parameter V_DISPLAY, default 480, meaning visible lines per frame.
REQ-006 SHALL have parameter V_FP, default 10, meaning vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 2, meaning vertical sync width in lines.
REQ-008 SHALL have parameter V_BP, default 33, meaning vertical back porch in lines.
REQ-009 SHALL have parameter DIV, default 4, meaning CLK_NEXYS cycles per pixel (100 MHz to 25 MHz).
REQ-010 SHALL have port CLK_NEXYS, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-011 SHALL have port RESET, input, 1 bit: reset, synchronous and active-high.
REQ-012 SHALL have port P_TICK, output, 1 bit: one-CLK_NEXYS-cycle pixel enable.
REQ-013 SHALL have port PIX_X, output, 10 bits: current horizontal count, 0..799.
REQ-014 SHALL have port PIX_Y, output, 10 bits: current vertical count, 0..524.
REQ-015 SHALL have port HSYNC, output, 1 bit: horizontal sync, active-low.
REQ-016 SHALL have port VSYNC, output, 1 bit: vertical sync, active-low.
REQ-017 SHALL have port VIDEO_ON, output, 1 bit: high while (PIX_X,PIX_Y) is in the visible area.
REQ-018 SHALL have port FRAME_START, output, 1 bit: one-cycle pulse when the counters wrap to (0,0).

Function
REQ-019 SHALL run a divider counting 0..DIV-1 every CLK_NEXYS cycle; P_TICK high exactly when the divider equals DIV-1.
REQ-020 SHALL advance the horizontal counter only in cycles with P_TICK high; it wraps from H_TOTAL-1 (799) to 0, where H_TOTAL=H_DISPLAY+H_FP+H_SYNC+H_BP.
REQ-021 SHALL advance the vertical counter only on a P_TICK cycle in which horizontal equals H_TOTAL-1; it wraps from V_TOTAL-1 (524) to 0.
REQ-022 SHALL drive PIX_X and PIX_Y directly from the counter registers, with no added latency.
REQ-023 SHALL register HSYNC, VSYNC and VIDEO_ON from the next-state counter values, so they stay aligned with PIX_X and PIX_Y in the same cycle.
REQ-024 SHALL drive HSYNC low exactly while PIX_X is in [H_DISPLAY+H_FP, H_DISPLAY+H_FP+H_SYNC-1] = [656,751].
REQ-025 SHALL drive VSYNC low exactly while PIX_Y is in [490,491].
REQ-026 SHALL drive VIDEO_ON high exactly while PIX_X<640 and PIX_Y<480.
REQ-027 SHALL assert FRAME_START, registered, for exactly one CLK_NEXYS cycle: the cycle in which the counters first read (0,0) after the wrap from (799,524).
REQ-028 SHALL use unsigned arithmetic for all comparisons, with the counters never exceeding H_TOTAL-1 or V_TOTAL-1.
REQ-029 SHALL have a frame period of 420000 P_TICKs, i.e. 1680000 CLK_NEXYS cycles, with default parameters.

Reset
REQ-030 SHALL, while RESET is high at a clock edge, set: divider=0, PIX_X=0, PIX_Y=0, HSYNC=1, VSYNC=1, VIDEO_ON=0, FRAME_START=0.
REQ-031 SHALL, on the first edge after RESET falls, set VIDEO_ON to the decode of (0,0) (i.e. 1); the first P_TICK follows DIV-1 cycles after release.
REQ-032 SHALL give RESET priority over P_TICK when both are active in the same cycle, including mid-frame and at the wrap point; no FRAME_START is produced by reset.

Structure
REQ-033 SHALL take the timing constants (H/V display, porch and sync values, H_TOTAL, V_TOTAL) from the shared package vga_timing_pkg, also used by the renderer.
REQ-034 SHALL place the divider in one sub-module, pix_tick_div, which outputs P_TICK.

Verification
REQ-035 SHALL cover: release RESET -> P_TICK every 4th CLK_NEXYS cycle; PIX_X goes 0->1 on the first tick; VIDEO_ON=1 one cycle after release.
REQ-036 SHALL cover: tick at PIX_X=799, PIX_Y=10 -> PIX_X=0, PIX_Y=11; HSYNC low for PIX_X 656..751 and high at 655 and 752.
REQ-037 SHALL cover: tick at (799,524) -> (0,0) with FRAME_START high for exactly one cycle; VSYNC low only on lines 490 and 491; 1680000 cycles between FRAME_START pulses.
REQ-038 SHALL cover: VIDEO_ON at (639,479)=1, (640,0)=0, (0,480)=0, (799,524)=0.
REQ-039 SHALL cover: RESET asserted at (300,200) coincident with P_TICK -> next cycle (0,0), HSYNC=1, VSYNC=1, VIDEO_ON=0, FRAME_START=0.
